// File: rtl/audio_playback.sv
// audio_playback: streams buffered samples to the audio output at the sample rate, one-shot or looped
module audio_playback #(
    parameter int CLK_FREQ      = 50000000,
    parameter int SAMPLE_RATE   = 48000,
    parameter int TOTAL_SAMPLES = 96000,
    parameter int ADDR_W        = 17,
    parameter int DATA_W        = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              stop,
    input  logic              loop_en,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_rd,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [DATA_W-1:0] audio_out,
    output logic              sample_valid,
    output logic              busy,
    output logic              done,
    output logic [17:0]       ledr
);
    localparam int DIV = CLK_FREQ / SAMPLE_RATE;
    localparam int DW  = $clog2(DIV);

    typedef enum logic [2:0] {IDLE, PRIME, LOAD, PLAY, DRAIN} state_t;

    state_t            state, state_n;
    logic [DW-1:0]     div, div_n;
    logic [DATA_W-1:0] next_sample, next_sample_n, audio_n;
    logic [ADDR_W-1:0] addr_n;
    logic [17:0]       ledr_n;
    logic              rd_n, rd_d, sv_n, done_n, tick, last;

    assign tick = div == DW'(DIV - 1);
    assign last = mem_addr == ADDR_W'(TOTAL_SAMPLES - 1);

    // next state and next register values; stop overrides everything outside IDLE
    always_comb begin
        state_n       = state;
        div_n         = tick ? '0 : div + 1'b1;
        addr_n        = mem_addr;
        rd_n          = 1'b0;
        audio_n       = audio_out;
        sv_n          = 1'b0;
        done_n        = 1'b0;
        ledr_n        = ledr;
        next_sample_n = rd_d ? mem_rdata : next_sample;
        case (state)
            IDLE: begin
                div_n = '0;
                if (start && !stop) begin
                    state_n = PRIME;
                    addr_n  = '0;
                    rd_n    = 1'b1;
                    ledr_n  = 18'h00001;
                end else if (stop) begin
                    ledr_n = '0;
                end
            end
            PRIME: begin
                div_n   = '0;
                state_n = LOAD;
            end
            LOAD: begin
                div_n         = '0;
                next_sample_n = mem_rdata;
                state_n       = PLAY;
            end
            PLAY: begin
                if (tick) begin
                    audio_n = next_sample;
                    sv_n    = 1'b1;
                    if (!last) begin
                        addr_n = mem_addr + 1'b1;
                        rd_n   = 1'b1;
                    end else if (loop_en) begin
                        addr_n = '0;
                        rd_n   = 1'b1;
                    end else begin
                        state_n = DRAIN;
                    end
                end
            end
            DRAIN: begin
                if (tick) begin
                    audio_n = '0;
                    done_n  = 1'b1;
                    ledr_n  = 18'h3FFFF;
                    state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
        if (stop && state != IDLE) begin
            state_n = IDLE;
            audio_n = '0;
            rd_n    = 1'b0;
            sv_n    = 1'b0;
            done_n  = 1'b0;
            ledr_n  = '0;
            div_n   = '0;
        end
    end

    // all state and outputs registered; rd_d marks the cycle the buffer data is valid
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            div          <= '0;
            next_sample  <= '0;
            mem_addr     <= '0;
            mem_rd       <= 1'b0;
            rd_d         <= 1'b0;
            audio_out    <= '0;
            sample_valid <= 1'b0;
            busy         <= 1'b0;
            done         <= 1'b0;
            ledr         <= '0;
        end else begin
            state        <= state_n;
            div          <= div_n;
            next_sample  <= next_sample_n;
            mem_addr     <= addr_n;
            mem_rd       <= rd_n;
            rd_d         <= mem_rd;
            audio_out    <= audio_n;
            sample_valid <= sv_n;
            busy         <= state_n != IDLE;
            done         <= done_n;
            ledr         <= ledr_n;
        end
    end
endmodule

// File: tb/tb_audio_playback.sv
// tb_audio_playback: directed vector bench for the playback engine with DIV=8, four samples
module tb_audio_playback;
    logic        clk = 1'b0, rst, start, stop, loop_en, mem_rd, sample_valid, busy, done;
    logic [16:0] mem_addr;
    logic [15:0] mem_rdata = '0, audio_out;
    logic [17:0] ledr;
    int          vecs = 0, errs = 0, nsv = 0, ndone = 0, nrd = 0, s0, d0, r0;

    typedef struct {
        logic        st, sp, lp;
        int          n;
        logic [15:0] au;
        logic        sv, by, dn, rd;
        logic [16:0] ad;
        logic [17:0] ld;
    } vec_t;
    vec_t v[$];

    audio_playback #(.CLK_FREQ(8), .SAMPLE_RATE(1), .TOTAL_SAMPLES(4), .ADDR_W(17), .DATA_W(16)) dut (
        .clk(clk), .rst(rst), .start(start), .stop(stop), .loop_en(loop_en),
        .mem_addr(mem_addr), .mem_rd(mem_rd), .mem_rdata(mem_rdata),
        .audio_out(audio_out), .sample_valid(sample_valid), .busy(busy), .done(done), .ledr(ledr)
    );

    always #5 clk = ~clk;

    // buffer model: 1-cycle synchronous read returning 0x0100 + addr
    always @(posedge clk) if (mem_rd) mem_rdata <= 16'h0100 + mem_addr[15:0];

    // pulse counters, sampled mid-cycle
    always @(negedge clk) begin
        if (sample_valid) nsv++;
        if (done) ndone++;
        if (mem_rd) nrd++;
    end

    function automatic void add(input logic st, sp, lp, input int n, input logic [15:0] au,
                                input logic sv, by, dn, rd, input logic [16:0] ad, input logic [17:0] ld);
        vec_t x;
        x.st = st; x.sp = sp; x.lp = lp; x.n = n; x.au = au;
        x.sv = sv; x.by = by; x.dn = dn; x.rd = rd; x.ad = ad; x.ld = ld;
        v.push_back(x);
    endfunction

    task automatic cmp(input string name, input int act, input int exp);
        vecs++;
        if (act != exp) begin
            errs++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic run(input int a, input int b);
        for (int i = a; i < b; i++) begin
            logic [54:0] act, exp;
            start = v[i].st; stop = v[i].sp; loop_en = v[i].lp;
            repeat (v[i].n) @(posedge clk);
            #1;
            act = {audio_out, sample_valid, busy, done, mem_rd, mem_addr, ledr};
            exp = {v[i].au, v[i].sv, v[i].by, v[i].dn, v[i].rd, v[i].ad, v[i].ld};
            vecs++;
            if (act !== exp) begin
                errs++;
                $display("FAIL vec%0d: got au=%h sv=%b busy=%b done=%b rd=%b addr=%0d ledr=%h, expected au=%h sv=%b busy=%b done=%b rd=%b addr=%0d ledr=%h",
                         i, audio_out, sample_valid, busy, done, mem_rd, mem_addr, ledr,
                         v[i].au, v[i].sv, v[i].by, v[i].dn, v[i].rd, v[i].ad, v[i].ld);
            end
        end
        start = 0; stop = 0;
    endtask

    initial begin
        // idle after reset, then start+stop together
        add(0,0,0, 3, 16'h0000,0,0,0,0, 0, 18'h0);
        add(1,1,0, 1, 16'h0000,0,0,0,0, 0, 18'h0);
        // one-shot pass (entries 2..11), start re-pulsed mid-play
        add(1,0,0, 1, 16'h0000,0,1,0,1, 0, 18'h1);
        add(0,0,0, 1, 16'h0000,0,1,0,0, 0, 18'h1);
        add(0,0,0, 9, 16'h0100,1,1,0,1, 1, 18'h1);
        add(0,0,0, 1, 16'h0100,0,1,0,0, 1, 18'h1);
        add(1,0,0, 3, 16'h0100,0,1,0,0, 1, 18'h1);
        add(0,0,0, 4, 16'h0101,1,1,0,1, 2, 18'h1);
        add(0,0,0, 8, 16'h0102,1,1,0,1, 3, 18'h1);
        add(0,0,0, 8, 16'h0103,1,1,0,0, 3, 18'h1);
        add(0,0,0, 8, 16'h0000,0,0,1,0, 3, 18'h3FFFF);
        add(0,0,0, 5, 16'h0000,0,0,0,0, 3, 18'h3FFFF);
        // looped pass with wrap, then stop 3 cycles after the 0101 update (entries 12..19)
        add(1,0,1, 1, 16'h0000,0,1,0,1, 0, 18'h1);
        add(0,0,1,10, 16'h0100,1,1,0,1, 1, 18'h1);
        add(0,0,1,24, 16'h0103,1,1,0,1, 0, 18'h1);
        add(0,0,1, 8, 16'h0100,1,1,0,1, 1, 18'h1);
        add(0,0,1, 8, 16'h0101,1,1,0,1, 2, 18'h1);
        add(0,0,1, 2, 16'h0101,0,1,0,0, 2, 18'h1);
        add(0,1,1, 1, 16'h0000,0,0,0,0, 2, 18'h0);
        add(0,0,0,10, 16'h0000,0,0,0,0, 2, 18'h0);

        rst = 1; start = 0; stop = 0; loop_en = 0;
        repeat (2) @(posedge clk);
        #1;
        cmp("reset_outputs", int'({audio_out, sample_valid, busy, done, mem_rd} == 0 && mem_addr == 0 && ledr == 0), 1);
        rst = 0;
        run(0, 2);

        s0 = nsv; d0 = ndone;
        run(2, 12);
        cmp("oneshot_sv_count", nsv - s0, 4);
        cmp("oneshot_done_count", ndone - d0, 1);

        s0 = nsv; d0 = ndone;
        run(12, 18);
        r0 = nrd;
        run(18, 20);
        cmp("loop_sv_count", nsv - s0, 6);
        cmp("loop_done_count", ndone - d0, 0);
        cmp("stop_no_rd", nrd - r0, 0);

        // async reset while draining the last sample
        run(2, 10);
        repeat (4) @(posedge clk);
        #1;
        cmp("drain_busy", int'(busy), 1);
        d0 = ndone;
        #2 rst = 1;
        #1;
        cmp("async_reset_outputs", int'({audio_out, sample_valid, busy, done, mem_rd} == 0 && mem_addr == 0 && ledr == 0), 1);
        repeat (2) @(posedge clk);
        #1 rst = 0;
        repeat (10) @(posedge clk);
        #1;
        cmp("reset_no_done", ndone - d0, 0);
        s0 = nsv; d0 = ndone;
        run(2, 12);
        cmp("replay_sv_count", nsv - s0, 4);
        cmp("replay_done_count", ndone - d0, 1);

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end
endmodule
